bus_sram_responder: RTL
=======================

Name: bus_sram_responder

Overview:
- Responder (slave) end of the SoC memory bus: the unified request that the bus arbiter drives toward memory (address, read, write, byte mask, write data) is served here.
- Each 64-bit request is bridged onto a 32-bit synchronous single-port SRAM with 1-cycle read latency, as two word accesses.
- Returns read data and a one-cycle ready pulse when the transaction completes.

Parameters:
- SRAM_ADDR_WIDTH, 16, width of the SRAM 32-bit-word address; the doubleword window is 2^(SRAM_ADDR_WIDTH-1) entries.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- address_in  input  64  byte address; bits [2:0] ignored; bits [SRAM_ADDR_WIDTH+1:3] form doubleword index idx; higher bits ignored (aliasing)
- read_in  input  1  read request, held until ready_out
- write_in  input  1  write request, held until ready_out
- write_mask_in  input  8  byte enables, bit n = byte n of write_value_in
- write_value_in  input  64  write data
- read_value_out  output  64  read data, valid in the ready cycle, held until next read completes
- ready_out  output  1  one-cycle completion pulse
- sram_addr  output  SRAM_ADDR_WIDTH  word address {idx, half}
- sram_en  output  1  access enable
- sram_we  output  1  write enable (only with sram_en)
- sram_be  output  4  byte enables for writes
- sram_wdata  output  32  write word
- sram_rdata  input  32  read word, valid the cycle after an enabled read

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, ready_out=0, read_value_out=0.
  - All sram_* outputs are 0, and stay 0 in IDLE and DONE.
- States: IDLE, RD_LO, RD_HI, RD_CAP, WR_LO, WR_HI, DONE.
- IDLE:
  - Latches idx, mask and data when a request is seen.
  - write_in=1 (regardless of read_in) selects a write:
    - mask[3:0]!=0 -> WR_LO;
    - else mask[7:4]!=0 -> WR_HI;
    - else -> DONE.
  - Otherwise read_in=1 selects a read -> RD_LO.
  - With no request, stays in IDLE.
- RD_LO: sram_en=1, we=0, addr={idx,0} -> RD_HI.
- RD_HI: sram_en=1, addr={idx,1}; latch sram_rdata into low buffer -> RD_CAP.
- RD_CAP: latch sram_rdata into high buffer; read_value_out <= {hi,lo} -> DONE.
- WR_LO: sram_en=1, we=1, be=mask[3:0], wdata=data[31:0], addr={idx,0}.
  - Next: WR_HI if mask[7:4]!=0, else DONE.
- WR_HI: sram_en=1, we=1, be=mask[7:4], wdata=data[63:32], addr={idx,1} -> DONE.
- DONE: ready_out=1 for exactly this cycle -> IDLE.
- Latency (request seen in IDLE at cycle T):
  - read: ready at T+4;
  - write: ready at T+3 (both halves), T+2 (one half), T+1 (mask=0, no SRAM access).
- Request stability and back-to-back operation:
  - Inputs are sampled only in IDLE; later changes to them are ignored.
  - The requester deasserts in the cycle after ready. A request still asserted in that cycle starts a new transaction.
- Simultaneous read_in and write_in: performed as a write only; read_value_out unchanged.
- Read data: read_value_out changes only in RD_CAP; writes never alter it.
- Reset mid-transaction:
  - Returns to IDLE next cycle with no further SRAM accesses and no ready pulse.
  - A WR_LO already issued stays in the SRAM (partial write allowed).
- SRAM outputs are combinational from state and latched registers only; no path from bus inputs to sram_* outside IDLE.

Test Plan:
- Reset then idle: hold reset 2 cycles, no requests for 10 cycles -> ready_out=0, sram_en=0, read_value_out=0 throughout.
- Full write/read: write address 0x18, mask 0xFF, data 0x1122334455667788 -> word 6=0x55667788, word 7=0x11223344, ready at T+3. Then read 0x18 -> ready at T+4, read_value_out=0x1122334455667788.
- Partial and empty masks:
  - mask 0xF0, data 0xAAAAAAAA_BBBBBBBB to 0x0 -> only word 1 written, ready at T+2.
  - mask 0x00 -> no sram_en, ready at T+1.
  - mask 0x03 -> be=0011 on word 0 only.
- Priority and alignment:
  - read_in=write_in=1 at 0x20 -> write sequence only, read_value_out unchanged.
  - address 0x27 -> same words (8, 9) as 0x20.
- Back-to-back: requester holds read_in one extra cycle after ready -> second read starts, second ready exactly 5 cycles after first.
- Reset mid-read: reset asserted in RD_HI -> next cycle IDLE, sram_en=0, no ready pulse, read_value_out=0.

Source files
------------

// File: rtl/bus_sram_responder.sv
// Responder end of the SoC memory bus: each 64-bit request is served as two
// 32-bit word accesses on a synchronous single-port SRAM with 1-cycle read latency.
module bus_sram_responder #(
  parameter int SRAM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [63:0]                address_in,
  input  logic                       read_in,
  input  logic                       write_in,
  input  logic [7:0]                 write_mask_in,
  input  logic [63:0]                write_value_in,
  output logic [63:0]                read_value_out,
  output logic                       ready_out,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_en,
  output logic                       sram_we,
  output logic [3:0]                 sram_be,
  output logic [31:0]                sram_wdata,
  input  logic [31:0]                sram_rdata
);

  localparam int IW = SRAM_ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    RD_CAP = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] idx;
  logic [7:0]    mask;
  logic [63:0]   data;
  logic [31:0]   lo_buf;

  // Byte offset and high address bits are don't-care (doubleword aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_in[63:SRAM_ADDR_WIDTH+2], address_in[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      mask           <= '0;
      data           <= '0;
      lo_buf         <= '0;
      read_value_out <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (read_in || write_in)) begin
        idx  <= address_in[SRAM_ADDR_WIDTH+1:3];
        mask <= write_mask_in;
        data <= write_value_in;
      end
      if (state == RD_HI) begin
        lo_buf <= sram_rdata;
      end
      if (state == RD_CAP) begin
        read_value_out <= {sram_rdata, lo_buf};
      end
    end
  end

  // SRAM drive depends only on state and latched request fields.
  always_comb begin
    state_next = state;
    ready_out  = 1'b0;
    sram_addr  = '0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_wdata = '0;
    case (state)
      IDLE: begin
        if (write_in) begin
          if (write_mask_in[3:0] != 4'b0000)      state_next = WR_LO;
          else if (write_mask_in[7:4] != 4'b0000) state_next = WR_HI;
          else                                    state_next = DONE;
        end else if (read_in) begin
          state_next = RD_LO;
        end
      end
      RD_LO: begin
        sram_en    = 1'b1;
        sram_addr  = {idx, 1'b0};
        state_next = RD_HI;
      end
      RD_HI: begin
        sram_en    = 1'b1;
        sram_addr  = {idx, 1'b1};
        state_next = RD_CAP;
      end
      RD_CAP: begin
        state_next = DONE;
      end
      WR_LO: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = mask[3:0];
        sram_wdata = data[31:0];
        sram_addr  = {idx, 1'b0};
        state_next = (mask[7:4] != 4'b0000) ? WR_HI : DONE;
      end
      WR_HI: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_be    = mask[7:4];
        sram_wdata = data[63:32];
        sram_addr  = {idx, 1'b1};
        state_next = DONE;
      end
      DONE: begin
        ready_out  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
